// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data SRAM port arbiter.
// Owner encoding and default sizing live here so the grant logic and top agree.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 3;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Counter must hold 0..limit; a limit of 0 still needs one bit to exist.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    if (limit < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(limit + 32'd1);
    end
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Per-cycle grant decision between fetch and load/store, with the starvation
// counter that forces a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic inst_cancel,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

  localparam int unsigned CNT_W = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  logic             force_inst_s;

  // Grant decision and starvation counter next state.
  always_comb begin
    force_inst_s     = inst_req & ~inst_cancel & (starve_cnt_r == LIMIT_C);
    grant_data       = data_req & ~force_inst_s;
    grant_inst       = inst_req & ~inst_cancel & ~grant_data;
    starve_cnt_nxt_s = starve_cnt_r;
    if (grant_inst || !inst_req) begin
      starve_cnt_nxt_s = '0;
    end else if (grant_data && !inst_cancel && (starve_cnt_r != LIMIT_C)) begin
      starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= '0;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and load/store.
// One access in flight; its response returns exactly one cycle after acceptance.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic   grant_inst_s;
  logic   grant_data_s;
  logic   resp_valid_r;
  owner_e resp_owner_r;
  logic   resp_wr_r;
  logic   resp_drop_r;

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_cancel(inst_cancel),
    .data_req   (data_req),
    .grant_inst (grant_inst_s),
    .grant_data (grant_data_s)
  );

  // Request acceptance and SRAM drive; everything is held at 0 during reset.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 4'b0000;
    sram_addr    = '0;
    sram_wdata   = '0;
    if (resetn) begin
      inst_addr_ok = grant_inst_s;
      data_addr_ok = grant_data_s;
      sram_en      = grant_inst_s | grant_data_s;
      if (grant_data_s) begin
        sram_addr  = data_addr;
        sram_wdata = data_wdata;
        sram_we    = data_wr ? data_wstrb : 4'b0000;
      end else if (grant_inst_s) begin
        sram_addr  = inst_addr;
      end else begin
        sram_addr  = '0;
      end
    end else begin
      inst_addr_ok = 1'b0;
    end
  end

  // Owner of the single in-flight access, consumed in the following cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid_r <= 1'b0;
      resp_owner_r <= OWNER_INST;
      resp_wr_r    <= 1'b0;
      resp_drop_r  <= 1'b0;
    end else begin
      resp_valid_r <= sram_en;
      resp_owner_r <= grant_data_s ? OWNER_DATA : OWNER_INST;
      resp_wr_r    <= grant_data_s & data_wr;
      resp_drop_r  <= 1'b0;
    end
  end

  // Response steering; a cancelled fetch still completes at the SRAM but is hidden.
  always_comb begin
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    if (resetn) begin
      inst_data_ok = resp_valid_r & (resp_owner_r == OWNER_INST) & ~resp_drop_r & ~inst_cancel;
      data_data_ok = resp_valid_r & (resp_owner_r == OWNER_DATA);
      inst_rdata   = sram_rdata;
      data_rdata   = resp_wr_r ? '0 : sram_rdata;
    end else begin
      inst_data_ok = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous SRAM.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] mem [1024];
  int total;
  int bad;

  mem_port_arbiter #(.STARVE_LIMIT(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after sram_en, byte writes.
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic ic,
                       input logic dr, input logic dw, input logic [3:0] ds,
                       input logic [31:0] da, input logic [31:0] dd);
    inst_req = ir; inst_addr = ia; inst_cancel = ic;
    data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
  endtask

  logic exp_d [6];

  initial begin
    total = 0;
    bad = 0;
    sram_rdata = 32'h0000_0000;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[64]  = 32'hDEAD_BEEF;
    mem[128] = 32'hCAFE_F00D;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset: outputs held low even with requests present
    resetn = 1'b0;
    drive(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h100, 32'h1);
    tick(); #4;
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    tick();
    resetn = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);

    // Inst only, three back-to-back fetches
    tick(); drive(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t1_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t1_c1_sram_addr", sram_addr, 32'h1C00_0000);
    chk("t1_c1_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t1_c1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    tick(); #4;
    chk("t1_c2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t1_c2_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t1_c2_inst_rdata", inst_rdata, 32'hA000_0000);
    tick(); #4;
    chk("t1_c3_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t1_c3_data_data_ok", 32'(data_data_ok), 32'd0);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t1_c4_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t1_c4_inst_rdata", inst_rdata, 32'hA000_0000);
    chk("t1_c4_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    tick(); #4;
    chk("t1_c5_inst_data_ok", 32'(inst_data_ok), 32'd0);

    // Load and fetch together: data first, then inst
    tick(); drive(1'b1, 32'h1C00_0004, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0); #4;
    chk("t2_c1_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("t2_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("t2_c1_sram_addr", sram_addr, 32'h100);
    tick(); drive(1'b1, 32'h1C00_0004, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t2_c2_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t2_c2_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("t2_c2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t2_c2_sram_addr", sram_addr, 32'h1C00_0004);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t2_c3_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t2_c3_inst_rdata", inst_rdata, 32'hA000_0001);
    chk("t2_c3_data_data_ok", 32'(data_data_ok), 32'd0);

    // Continuous contention with LIMIT=3: D,D,D,I,D,D
    for (int k = 0; k < 6; k++) begin
      tick(); drive(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0); #4;
      chk($sformatf("t3_c%0d_data_addr_ok", k), 32'(data_addr_ok), 32'(exp_d[k]));
      chk($sformatf("t3_c%0d_inst_addr_ok", k), 32'(inst_addr_ok), 32'(!exp_d[k]));
      if (k > 0) chk($sformatf("t3_c%0d_data_data_ok", k), 32'(data_data_ok), 32'(exp_d[k-1]));
    end
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t3_tail_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t3_tail_data_rdata", data_rdata, 32'hDEAD_BEEF);

    // Partial store, then readback
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234_5678); #4;
    chk("t4_c1_sram_we", 32'(sram_we), 32'h3);
    chk("t4_c1_sram_wdata", sram_wdata, 32'h1234_5678);
    chk("t4_c1_data_addr_ok", 32'(data_addr_ok), 32'd1);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h200, 32'h0); #4;
    chk("t4_c2_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t4_c2_data_rdata", data_rdata, 32'h0000_0000);
    chk("t4_c2_sram_we", 32'(sram_we), 32'h0);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t4_c3_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t4_c3_data_rdata", data_rdata, 32'hCAFE_5678);

    // Fetch cancelled in its response cycle
    tick(); drive(1'b1, 32'h1C00_0008, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t5_n_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    tick(); drive(1'b1, 32'h1C00_000C, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t5_n1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("t5_n1_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t5_n1_sram_en", 32'(sram_en), 32'd0);
    tick(); drive(1'b1, 32'h1C00_0010, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t5_n2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t5_n2_inst_data_ok", 32'(inst_data_ok), 32'd0);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t5_n3_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t5_n3_inst_rdata", inst_rdata, 32'hA000_0004);

    // Build starve count to 3, reset right after a load is accepted
    for (int k = 0; k < 3; k++) begin
      tick(); drive(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0); #4;
      chk($sformatf("t6_pre%0d_data_addr_ok", k), 32'(data_addr_ok), 32'd1);
    end
    tick(); resetn = 1'b0; #4;
    chk("t6_rst_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("t6_rst_sram_en", 32'(sram_en), 32'd0);
    chk("t6_rst_data_rdata", data_rdata, 32'h0);
    tick(); #4;
    chk("t6_rst2_data_data_ok", 32'(data_data_ok), 32'd0);
    tick(); resetn = 1'b1; #4;
    chk("t6_r0_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("t6_r0_data_data_ok", 32'(data_data_ok), 32'd0);
    tick(); #4;
    chk("t6_r1_data_data_ok", 32'(data_data_ok), 32'd1);
    chk("t6_r1_data_addr_ok", 32'(data_addr_ok), 32'd1);
    tick(); #4;
    chk("t6_r2_data_addr_ok", 32'(data_addr_ok), 32'd1);
    tick(); #4;
    chk("t6_r3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t6_r3_data_addr_ok", 32'(data_addr_ok), 32'd0);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0); #4;
    chk("t6_r4_inst_data_ok", 32'(inst_data_ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single synchronous data SRAM port between the instruction-fetch requester and the EXE-stage load/store requester. Each requester uses a req/addr_ok/data_ok handshake; the arbiter grants one request per cycle and tracks the owner of the one in-flight SRAM access. It returns the response one cycle later and applies a starvation limit so fetch progresses under back-to-back memory instructions. It sits between the pipeline stages (IF, EXE, MEM) and the SRAM.

Parameters:
STARVE_LIMIT, 3, max consecutive data grants while inst_req is pending before inst is forced; 0 = inst wins every conflict
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request valid
inst_addr  in  ADDR_W  fetch address
inst_cancel  in  1  discard any fetch not yet returned (branch redirect)
inst_addr_ok  out  1  fetch accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  DATA_W  fetch data
data_req  in  1  load/store request valid
data_wr  in  1  1 = store
data_wstrb  in  4  byte strobes for store
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  load/store accepted this cycle
data_data_ok  out  1  load data valid / store complete this cycle
data_rdata  out  DATA_W  load data
sram_en  out  1  SRAM enable
sram_we  out  4  SRAM byte write enables
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en

Behaviour:
- Grant, combinational, every cycle:
  - force_inst = inst_req & ~inst_cancel & (starve_cnt == STARVE_LIMIT)
  - grant_data = data_req & ~force_inst
  - grant_inst = inst_req & ~inst_cancel & ~grant_data
- Acceptance and SRAM drive:
  - inst_addr_ok = grant_inst; data_addr_ok = grant_data
  - sram_en = grant_inst | grant_data; sram_addr/sram_wdata from the granted requester (don't-care when idle)
  - sram_we = data_wstrb when grant_data & data_wr, else 4'b0
- Both requests present with starve_cnt < LIMIT: data wins. Throughput is one accepted request per cycle; latency is exactly 1 cycle from addr_ok to data_ok.
- Response registers (cleared by reset): resp_valid, resp_owner (0 = INST, 1 = DATA), resp_wr, resp_drop.
  - On each edge: resp_valid <= sram_en; resp_owner <= grant_data; resp_wr <= grant_data & data_wr; resp_drop <= 0.
- Outputs in the response cycle:
  - inst_data_ok = resp_valid & ~resp_owner & ~resp_drop & ~inst_cancel
  - data_data_ok = resp_valid & resp_owner
  - inst_rdata = sram_rdata
  - data_rdata = resp_wr ? 0 : sram_rdata
  - Requesters must accept data_ok; there is no response backpressure.
- Cancel:
  - inst_cancel masks inst_data_ok in the response cycle and blocks inst grant in the same cycle.
  - An inst access already issued still completes at the SRAM; only its response is discarded.
  - Data traffic is never affected.
- Starve counter, width clog2(STARVE_LIMIT+1):
  - Increments (saturating at LIMIT) when grant_data & inst_req & ~inst_cancel.
  - Clears to 0 on grant_inst or when inst_req is low.
- Reset (async, any time, including mid-access): every response register and starve_cnt go to 0. No data_ok is emitted for a request accepted before reset. All outputs are 0 while resetn is low.

Decomposition:
- Shared package: OWNER_INST/OWNER_DATA constants, default STARVE_LIMIT, ADDR_W/DATA_W.
- One sub-module, mem_arb_grant: combinational grant plus the starve counter. The top module holds the response registers and the muxes.

Test Plan:
- Inst only, inst_addr=0x1C000000 for 3 cycles -> inst_addr_ok=1 each cycle; inst_data_ok=1 cycles 2-4 with matching SRAM words; data_* idle.
- Load at 0x100 (sram word 0xDEADBEEF) and fetch in the same cycle, LIMIT=3 -> data granted first; data_data_ok=1 with data_rdata=0xDEADBEEF next cycle; inst granted the following cycle.
- Continuous data_req for 6 cycles plus continuous inst_req, LIMIT=3 -> grant order D,D,D,I,D,D; starve_cnt resets after I.
- Store wstrb=4'b0011, wdata=0x12345678 at 0x200 -> sram_we=4'b0011 that cycle; data_data_ok=1 next cycle with data_rdata=0; readback 0x200 returns the low halfword updated.
- Fetch accepted at cycle N, inst_cancel=1 in cycle N+1 -> inst_data_ok stays 0, inst_addr_ok=0 in N+1; a fetch at N+2 returns normally at N+3.
- resetn low in the cycle after a load is accepted -> data_data_ok never asserts; after release, first request behaves as from reset with starve_cnt=0.
